// File: rtl/dsp_seq_pkg.sv
// Shared constants and the beat tag type for the DSP48A1 MAC sequencer.
// Only the two MAC opmodes (X=M with Z=0 or Z=P) are ever issued to the slice.
package dsp_seq_pkg;

   localparam logic [7:0] OPM_ZERO      = 8'h00;
   localparam logic [7:0] OPM_MAC_FIRST = 8'h01;
   localparam logic [7:0] OPM_MAC_ACC   = 8'h09;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   typedef struct packed {
      logic vld;
      logic first;
      logic last;
   } beat_tag_t;

   function automatic logic [7:0] mac_opmode(input logic first);
      return first ? OPM_MAC_FIRST : OPM_MAC_ACC;
   endfunction

endpackage

// File: rtl/dsp_beat_tracker.sv
// Shadows the slice's AB -> M -> P register chain with one tag per accepted beat,
// so the M/P enables follow the operands through bubbles.
module dsp_beat_tracker
   import dsp_seq_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  logic beat,
   input  logic first,
   input  logic last,
   output logic cem,
   output logic cep,
   output logic ab_first,
   output logic m_first,
   output logic m_last,
   output logic p_vld,
   output logic p_last
);

   beat_tag_t ab_tag;
   beat_tag_t m_tag;

   // The P stage drops 'first': the opmode has been issued by the time a tag reaches P.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ab_tag <= '0;
         m_tag  <= '0;
         p_vld  <= 1'b0;
         p_last <= 1'b0;
      end else if (flush) begin
         ab_tag <= '0;
         m_tag  <= '0;
         p_vld  <= 1'b0;
         p_last <= 1'b0;
      end else begin
         ab_tag <= '{vld: beat, first: first & beat, last: last & beat};
         m_tag  <= ab_tag;
         p_vld  <= m_tag.vld;
         p_last <= m_tag.last;
      end
   end

   assign cem      = ab_tag.vld;
   assign cep      = m_tag.vld;
   assign ab_first = ab_tag.first;
   assign m_first  = m_tag.first;
   assign m_last   = m_tag.last;

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequences a DSP48A1 slice (AREG/BREG=1, MREG=1, PREG=1) through an N-term MAC,
// taking operand beats over valid/ready and pulsing done when P holds the sum.
module dsp_mac_sequencer
   import dsp_seq_pkg::*;
#(
   parameter int LEN_WIDTH  = 8,
   parameter int OPMODE_REG = 1
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [LEN_WIDTH-1:0] len,
   input  logic                 abort,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 cea,
   output logic                 ceb,
   output logic                 cem,
   output logic                 cep,
   output logic                 ceopmode,
   output logic [7:0]           opmode,
   output logic                 rstp,
   output logic                 busy,
   output logic                 done,
   output logic                 start_err
);

   logic [1:0]           state;
   logic [LEN_WIDTH-1:0] remaining;
   logic                 first_pend;
   logic                 accept;
   logic                 flush;
   logic                 last_beat;
   logic                 ab_first;
   logic                 m_first;
   logic                 m_last;
   logic                 p_vld;
   logic                 p_last;
   logic                 op_issue;
   logic                 op_first;
   logic [7:0]           opmode_hold;

   assign accept    = in_valid & in_ready;
   assign cea       = accept;
   assign ceb       = accept;
   assign busy      = (state != IDLE);
   assign flush     = abort & busy;
   assign last_beat = (remaining == LEN_WIDTH'(1));
   assign done      = p_vld & p_last;

   // Abort outranks every beat and state transition; rstp is its one-cycle echo.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         remaining  <= '0;
         first_pend <= 1'b0;
         in_ready   <= 1'b0;
         rstp       <= 1'b0;
         start_err  <= 1'b0;
      end else begin
         rstp      <= 1'b0;
         start_err <= 1'b0;
         if (flush) begin
            state      <= IDLE;
            remaining  <= '0;
            first_pend <= 1'b0;
            in_ready   <= 1'b0;
            rstp       <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     if (len != '0) begin
                        state      <= ISSUE;
                        remaining  <= len;
                        first_pend <= 1'b1;
                        in_ready   <= 1'b1;
                     end else begin
                        start_err <= 1'b1;
                     end
                  end
               end
               ISSUE: begin
                  if (accept) begin
                     remaining  <= remaining - LEN_WIDTH'(1);
                     first_pend <= 1'b0;
                     if (last_beat) begin
                        state    <= DRAIN;
                        in_ready <= 1'b0;
                     end
                  end
               end
               DRAIN: begin
                  if (cep & m_last) begin
                     state <= IDLE;
                  end
               end
               default: begin
                  state    <= IDLE;
                  in_ready <= 1'b0;
               end
            endcase
         end
      end
   end

   dsp_beat_tracker u_tracker (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .beat     (accept),
      .first    (first_pend),
      .last     (last_beat),
      .cem      (cem),
      .cep      (cep),
      .ab_first (ab_first),
      .m_first  (m_first),
      .m_last   (m_last),
      .p_vld    (p_vld),
      .p_last   (p_last)
   );

   // A registered OPMODE must be loaded one stage early, alongside the M register.
   assign op_issue = (OPMODE_REG != 0) ? cem : cep;
   assign op_first = (OPMODE_REG != 0) ? ab_first : m_first;
   assign ceopmode = op_issue;
   assign opmode   = op_issue ? mac_opmode(op_first) : opmode_hold;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opmode_hold <= OPM_ZERO;
      end else if (op_issue) begin
         opmode_hold <= mac_opmode(op_first);
      end
   end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer: runs a registered-OPMODE and a combinational-OPMODE
// instance side by side, each feeding a small DSP48A1 MAC model to check the final sum.
module tb_dsp_mac_sequencer;

   localparam int LW   = 8;
   localparam int MAXC = 14;

   typedef struct {
      int          len;
      logic [15:0] vpat;
      int          bs_off;
      logic [31:0] exp_ready;
      logic [31:0] exp_cem;
      logic [31:0] exp_cep;
      int          exp_done;
      longint      exp_p;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [LW-1:0] len;
   logic          abort;
   logic          in_valid;
   logic [17:0]   a_in;
   logic [17:0]   b_in;

   logic       in_ready1, cea1, ceb1, cem1, cep1, ceopmode1, rstp1, busy1, done1, start_err1;
   logic [7:0] opmode1;
   logic       in_ready0, cea0, ceb0, cem0, cep0, ceopmode0, rstp0, busy0, done0, start_err0;
   logic [7:0] opmode0;

   logic [17:0] a_reg1, b_reg1, a_reg0, b_reg0;
   logic [47:0] m_reg1, m_reg0, p_model1, p_model0;
   logic [7:0]  opm_reg1;

   int   vec_cnt = 0;
   int   miscompares = 0;
   vec_t vecs[5];

   always #5 clk = ~clk;

   dsp_mac_sequencer #(.LEN_WIDTH(LW), .OPMODE_REG(1)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort), .in_valid(in_valid),
      .in_ready(in_ready1), .cea(cea1), .ceb(ceb1), .cem(cem1), .cep(cep1),
      .ceopmode(ceopmode1), .opmode(opmode1), .rstp(rstp1), .busy(busy1),
      .done(done1), .start_err(start_err1)
   );

   dsp_mac_sequencer #(.LEN_WIDTH(LW), .OPMODE_REG(0)) dut_nr (
      .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort), .in_valid(in_valid),
      .in_ready(in_ready0), .cea(cea0), .ceb(ceb0), .cem(cem0), .cep(cep0),
      .ceopmode(ceopmode0), .opmode(opmode0), .rstp(rstp0), .busy(busy0),
      .done(done0), .start_err(start_err0)
   );

   // Slice models: Z=P when OPMODE[3:2]==2'b10, otherwise Z=0; X is always M.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg1 <= '0; b_reg1 <= '0; m_reg1 <= '0; p_model1 <= '0; opm_reg1 <= '0;
         a_reg0 <= '0; b_reg0 <= '0; m_reg0 <= '0; p_model0 <= '0;
      end else begin
         if (cea1) a_reg1 <= a_in;
         if (ceb1) b_reg1 <= b_in;
         if (cem1) m_reg1 <= {30'd0, a_reg1} * {30'd0, b_reg1};
         if (ceopmode1) opm_reg1 <= opmode1;
         if (rstp1) p_model1 <= '0;
         else if (cep1) p_model1 <= (opm_reg1[3:2] == 2'b10) ? p_model1 + m_reg1 : m_reg1;
         if (cea0) a_reg0 <= a_in;
         if (ceb0) b_reg0 <= b_in;
         if (cem0) m_reg0 <= {30'd0, a_reg0} * {30'd0, b_reg0};
         if (rstp0) p_model0 <= '0;
         else if (cep0) p_model0 <= (opmode0[3:2] == 2'b10) ? p_model0 + m_reg0 : m_reg0;
      end
   end

   task automatic checkOutput(input string name, input longint act, input longint exp);
      vec_cnt++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One run: start in offset 0, then MAXC cycles of beats with A=k, B=2k for beat k.
   task automatic applyStimulus(input vec_t v, input string name);
      logic [31:0] rdy1, rdy0, cemm1, cemm0, cepm1, cepm0, ceom1, ceom0;
      int          done_off1, done_off0, done_cnt1, done_cnt0, ops1, ops0, beats, err_cnt, rstp_cnt;
      longint      p_done1, p_done0;
      rdy1 = '0; rdy0 = '0; cemm1 = '0; cemm0 = '0; cepm1 = '0; cepm0 = '0; ceom1 = '0; ceom0 = '0;
      done_off1 = -1; done_off0 = -1; done_cnt1 = 0; done_cnt0 = 0;
      ops1 = 0; ops0 = 0; beats = 0; err_cnt = 0; rstp_cnt = 0; p_done1 = 0; p_done0 = 0;
      @(posedge clk); #1;
      start = 1'b1; len = LW'(v.len); in_valid = 1'b0; abort = 1'b0;
      for (int c = 1; c <= MAXC; c++) begin
         @(posedge clk); #1;
         start    = (c == v.bs_off);
         len      = (c == v.bs_off) ? LW'(7) : LW'(v.len);
         in_valid = v.vpat[c-1];
         a_in     = 18'(beats + 1);
         b_in     = 18'(2 * (beats + 1));
         @(negedge clk);
         rdy1[c] = in_ready1; rdy0[c] = in_ready0;
         cemm1[c] = cem1; cemm0[c] = cem0;
         cepm1[c] = cep1; cepm0[c] = cep0;
         ceom1[c] = ceopmode1; ceom0[c] = ceopmode0;
         if (c == 1) checkOutput({name, " busy_early"}, busy1, 1);
         if (ceopmode1) begin
            checkOutput({name, " opmode_reg"}, opmode1, (ops1 == 0) ? 8'h01 : 8'h09);
            ops1++;
         end
         if (ceopmode0) begin
            checkOutput({name, " opmode_comb"}, opmode0, (ops0 == 0) ? 8'h01 : 8'h09);
            ops0++;
         end
         if (done1) begin
            done_cnt1++;
            if (done_off1 < 0) begin done_off1 = c; p_done1 = longint'(p_model1); end
         end
         if (done0) begin
            done_cnt0++;
            if (done_off0 < 0) begin done_off0 = c; p_done0 = longint'(p_model0); end
         end
         if (start_err1 | start_err0) err_cnt++;
         if (rstp1 | rstp0) rstp_cnt++;
         if (in_valid & in_ready1) beats++;
      end
      in_valid = 1'b0;
      checkOutput({name, " in_ready_mask"}, rdy1, v.exp_ready);
      checkOutput({name, " in_ready_mask_nr"}, rdy0, v.exp_ready);
      checkOutput({name, " cem_mask"}, cemm1, v.exp_cem);
      checkOutput({name, " cep_mask"}, cepm1, v.exp_cep);
      checkOutput({name, " cem_mask_nr"}, cemm0, v.exp_cem);
      checkOutput({name, " cep_mask_nr"}, cepm0, v.exp_cep);
      checkOutput({name, " ceopmode_with_cem"}, ceom1, v.exp_cem);
      checkOutput({name, " ceopmode_with_cep_nr"}, ceom0, v.exp_cep);
      checkOutput({name, " opmode_count"}, ops1, v.len);
      checkOutput({name, " done_cycle"}, done_off1, v.exp_done);
      checkOutput({name, " done_cycle_nr"}, done_off0, v.exp_done);
      checkOutput({name, " done_pulses"}, done_cnt1, 1);
      checkOutput({name, " done_pulses_nr"}, done_cnt0, 1);
      checkOutput({name, " sum"}, p_done1, v.exp_p);
      checkOutput({name, " sum_nr"}, p_done0, v.exp_p);
      checkOutput({name, " busy_after"}, {busy1, busy0}, 0);
      checkOutput({name, " start_err"}, err_cnt, 0);
      checkOutput({name, " rstp"}, rstp_cnt, 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int quiet;
      // Masks are indexed by cycle offset from the start cycle.
      vecs[0] = '{len: 4, vpat: 16'hFFFF, bs_off: 0, exp_ready: 32'h1E, exp_cem: 32'h3C,
                  exp_cep: 32'h78, exp_done: 7, exp_p: 60};
      vecs[1] = '{len: 3, vpat: 16'hFFF9, bs_off: 0, exp_ready: 32'h3E, exp_cem: 32'h64,
                  exp_cep: 32'hC8, exp_done: 8, exp_p: 28};
      vecs[2] = '{len: 1, vpat: 16'hFFFF, bs_off: 0, exp_ready: 32'h02, exp_cem: 32'h04,
                  exp_cep: 32'h08, exp_done: 4, exp_p: 2};
      vecs[3] = '{len: 2, vpat: 16'hFFFF, bs_off: 0, exp_ready: 32'h06, exp_cem: 32'h0C,
                  exp_cep: 32'h18, exp_done: 5, exp_p: 10};
      vecs[4] = '{len: 3, vpat: 16'hFFFF, bs_off: 2, exp_ready: 32'h0E, exp_cem: 32'h1C,
                  exp_cep: 32'h38, exp_done: 6, exp_p: 28};

      rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0;
      #2;
      checkOutput("reset_outputs",
                  {busy1, in_ready1, cea1, cem1, cep1, ceopmode1, opmode1, rstp1, done1, start_err1,
                   busy0, in_ready0, cea0, cem0, cep0, ceopmode0, opmode0, rstp0, done0, start_err0}, 0);
      @(posedge clk); #2;
      rst = 1'b0;

      for (int i = 0; i < 5; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

      // len==0: error pulse only, never busy.
      @(posedge clk); #1;
      start = 1'b1; len = '0;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      checkOutput("len0 start_err", {start_err1, start_err0}, 2'b11);
      checkOutput("len0 busy", {busy1, busy0}, 0);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("len0 start_err_pulse", {start_err1, start_err0}, 0);

      // Abort after two of five beats, with a third beat offered in the abort cycle.
      @(posedge clk); #1;
      start = 1'b1; len = LW'(5);
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b1; a_in = 18'd1; b_in = 18'd2;
      @(posedge clk); #1;
      a_in = 18'd2; b_in = 18'd4;
      @(posedge clk); #1;
      a_in = 18'd3; b_in = 18'd6; abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      checkOutput("abort busy", {busy1, busy0}, 0);
      checkOutput("abort rstp", {rstp1, rstp0}, 2'b11);
      checkOutput("abort enables",
                  {in_ready1, cea1, ceb1, cem1, cep1, ceopmode1, in_ready0, cea0, ceb0, cem0, cep0, ceopmode0}, 0);
      quiet = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (c == 0) begin
            checkOutput("abort rstp_pulse", {rstp1, rstp0}, 0);
            checkOutput("abort p_cleared", longint'(p_model1), 0);
         end
         if (cem1 | cep1 | done1 | cem0 | cep0 | done0 | rstp1 | rstp0) quiet++;
      end
      checkOutput("abort quiet_after", quiet, 0);
      applyStimulus(vecs[3], "after_abort");

      // Asynchronous reset landing mid-cycle while the last term drains into P.
      @(posedge clk); #1;
      start = 1'b1; len = LW'(4);
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         start = 1'b0; in_valid = 1'b1; a_in = 18'(k); b_in = 18'(2 * k);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #2;
      checkOutput("drain busy_before_rst", {busy1, cep1, busy0, cep0}, 4'b1111);
      rst = 1'b1;
      #1;
      checkOutput("rst_mid_drain outputs",
                  {busy1, in_ready1, cea1, cem1, cep1, ceopmode1, opmode1, rstp1, done1, start_err1,
                   busy0, in_ready0, cea0, cem0, cep0, ceopmode0, opmode0, rstp0, done0, start_err0}, 0);
      @(posedge clk); #3;
      rst = 1'b0;
      quiet = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (done1 | done0 | busy1 | busy0) quiet++;
      end
      checkOutput("rst_mid_drain no_done", quiet, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
      $finish;
   end

endmodule
